// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage between the PC register and the
//               IF/ID pipeline register. It issues instruction-memory
//               requests over a ready handshake, loads IF/ID with
//               {instr, pc, pc+PC_INC}, and drives pc_pause so the PC only
//               advances once the current address has been committed.
//               It handles decode back-pressure (id_stall) and redirects
//               (flush).
//               Optional feature macro: FETCH_STALL_CNT_EN adds a saturating
//               stall_count output that counts non-idle cycles with the PC
//               held.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int PC_INC  = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_pause,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    input  logic               id_stall,
    input  logic               flush,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc_plus2
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_pc_inc = ADDR_W'(PC_INC);

    // Reject degenerate widths at elaboration time.
    generate
        if (ADDR_W < 1 || INSTR_W < 1 || CNT_W < 1) begin : g_bad_params
            $error("fetch_stage: ADDR_W, INSTR_W and CNT_W must all be at least 1");
        end
    endgenerate

    state_t               r_state;
    logic                 r_valid;
    logic [INSTR_W-1:0]   r_instr;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    r_pc_plus2;
    logic [INSTR_W-1:0]   r_buf_instr;
    logic [ADDR_W-1:0]    r_buf_pc;
    logic [ADDR_W-1:0]    r_req_addr;

    logic                 w_ld;
    logic                 w_pc_pause;

    // IF/ID may be overwritten when it is empty or decode is consuming it.
    assign w_ld = !r_valid || !id_stall;

    // Requests are live in FETCH (current PC) and DRAIN (abandoned address,
    // kept stable until the memory completes it).
    assign imem_req  = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    assign imem_addr = (r_state == ST_DRAIN) ? r_req_addr : pc_addr;
    assign pc_pause  = w_pc_pause;

    assign if_id_valid    = r_valid;
    assign if_id_instr    = r_instr;
    assign if_id_pc       = r_pc;
    assign if_id_pc_plus2 = r_pc_plus2;

    // PC advance decision: release the PC on a redirect or when an
    // instruction for the current address is committed this cycle.
    always_comb begin
        w_pc_pause = 1'b1;
        case (r_state)
            ST_FETCH: w_pc_pause = !(flush || (imem_ready && w_ld));
            ST_HOLD:  w_pc_pause = !(flush || w_ld);
            ST_DRAIN: w_pc_pause = !flush;
            default:  w_pc_pause = 1'b1;
        endcase
    end

    // Fetch state machine together with the IF/ID register and side buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_valid     <= 1'b0;
            r_instr     <= '0;
            r_pc        <= '0;
            r_pc_plus2  <= '0;
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
            r_req_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (flush) begin
                        // Redirect: whatever returns for the old PC is dropped.
                        r_valid <= 1'b0;
                        if (!imem_ready) begin
                            r_req_addr <= pc_addr;
                            r_state    <= ST_DRAIN;
                        end
                    end else if (imem_ready) begin
                        if (w_ld) begin
                            r_valid    <= 1'b1;
                            r_instr    <= imem_rdata;
                            r_pc       <= pc_addr;
                            r_pc_plus2 <= pc_addr + c_pc_inc;
                        end else begin
                            // Decode is stalled: park the word until it drains.
                            r_buf_instr <= imem_rdata;
                            r_buf_pc    <= pc_addr;
                            r_state     <= ST_HOLD;
                        end
                    end else if (w_ld) begin
                        // Decode consumed IF/ID and nothing replaces it: bubble.
                        r_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (flush) begin
                        r_valid <= 1'b0;
                        r_state <= ST_FETCH;
                    end else if (w_ld) begin
                        r_valid    <= 1'b1;
                        r_instr    <= r_buf_instr;
                        r_pc       <= r_buf_pc;
                        r_pc_plus2 <= r_buf_pc + c_pc_inc;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    r_valid <= 1'b0;
                    if (!flush && imem_ready) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_count;

    assign stall_count = r_stall_count;

    // Saturating count of active cycles in which the PC is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if ((r_state != ST_IDLE) && w_pc_pause &&
                     (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: a directed vector table,
//               hand-written reset/wrap sequences, and randomized traffic
//               against a transaction-level reference model with an
//               emulated PC register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_addr;
    logic        pc_pause;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        id_stall;
    logic        flush;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_plus2;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .ADDR_W (16),
        .INSTR_W(16),
        .PC_INC (2),
        .CNT_W  (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_addr       (pc_addr),
        .pc_pause      (pc_pause),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .id_stall      (id_stall),
        .flush         (flush),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_pc_plus2(if_id_pc_plus2)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_count   (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [15:0] pc;
        logic        rdy;
        logic [15:0] rdata;
        logic        stall;
        logic        flsh;
        logic        e_pause;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
    } vec_t;

    vec_t vq[$];

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } word_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] pc, input logic rdy, input logic [15:0] rdata,
                       input logic stall, input logic flsh,
                       input logic e_pause, input logic e_req, input logic [15:0] e_addr,
                       input logic e_valid, input logic [15:0] e_instr, input logic [15:0] e_pc);
        vec_t v;
        v.pc = pc; v.rdy = rdy; v.rdata = rdata; v.stall = stall; v.flsh = flsh;
        v.e_pause = e_pause; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc;
        vq.push_back(v);
    endtask

    // One clock cycle: called at posedge+1, returns at next posedge+1.
    task automatic run_vec(input vec_t v, input int idx);
        logic [15:0] p2;
        pc_addr    = v.pc;
        imem_ready = v.rdy;
        imem_rdata = v.rdata;
        id_stall   = v.stall;
        flush      = v.flsh;
        #4;
        chk($sformatf("vec%0d pc_pause", idx), 32'(pc_pause), 32'(v.e_pause));
        chk($sformatf("vec%0d imem_req", idx), 32'(imem_req), 32'(v.e_req));
        if (v.e_req) chk($sformatf("vec%0d imem_addr", idx), 32'(imem_addr), 32'(v.e_addr));
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d if_id_valid", idx), 32'(if_id_valid), 32'(v.e_valid));
        if (v.e_valid) begin
            p2 = v.e_pc + 16'd2;
            chk($sformatf("vec%0d if_id_instr", idx), 32'(if_id_instr), 32'(v.e_instr));
            chk($sformatf("vec%0d if_id_pc", idx), 32'(if_id_pc), 32'(v.e_pc));
            chk($sformatf("vec%0d if_id_pc_plus2", idx), 32'(if_id_pc_plus2), 32'(p2));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " pc_pause"}, 32'(pc_pause), 32'd1);
        chk({tag, " imem_req"}, 32'(imem_req), 32'd0);
        chk({tag, " if_id_valid"}, 32'(if_id_valid), 32'd0);
        chk({tag, " if_id_instr"}, 32'(if_id_instr), 32'd0);
        chk({tag, " if_id_pc"}, 32'(if_id_pc), 32'd0);
        chk({tag, " if_id_pc_plus2"}, 32'(if_id_pc_plus2), 32'd0);
    endtask

    // Reference model state (transaction level).
    bit          m_started;
    bit          m_draining;
    logic [15:0] m_drain_addr;
    word_t       m_buf[$];
    bit          m_valid;
    logic [15:0] m_instr;
    logic [15:0] m_pc;
    int          m_cnt;

    initial begin
        logic [15:0] tb_pc;
        logic        r_rdy, r_stall, r_flush, acc, e_pause, e_req, was_started;
        logic [15:0] r_rdata, e_addr, e_p2;
        word_t       w;

        rst_n = 1'b0; pc_addr = '0; imem_rdata = '0; imem_ready = 1'b0;
        id_stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // ---------------- directed vector table ----------------
        add(16'h0000,1'b1,16'h1111,1'b0,1'b0, 1'b1,1'b0,16'h0000, 1'b0,16'h0000,16'h0000);
        add(16'h0000,1'b1,16'h1111,1'b0,1'b0, 1'b0,1'b1,16'h0000, 1'b1,16'h1111,16'h0000);
        add(16'h0002,1'b1,16'h2222,1'b0,1'b0, 1'b0,1'b1,16'h0002, 1'b1,16'h2222,16'h0002);
        add(16'h0010,1'b0,16'h0000,1'b1,1'b0, 1'b1,1'b1,16'h0010, 1'b1,16'h2222,16'h0002);
        add(16'h0010,1'b0,16'h0000,1'b1,1'b0, 1'b1,1'b1,16'h0010, 1'b1,16'h2222,16'h0002);
        add(16'h0010,1'b0,16'h0000,1'b1,1'b0, 1'b1,1'b1,16'h0010, 1'b1,16'h2222,16'h0002);
        add(16'h0010,1'b1,16'h3333,1'b0,1'b0, 1'b0,1'b1,16'h0010, 1'b1,16'h3333,16'h0010);
        add(16'h0012,1'b1,16'hABCD,1'b1,1'b0, 1'b1,1'b1,16'h0012, 1'b1,16'h3333,16'h0010);
        add(16'h0012,1'b1,16'h0000,1'b1,1'b0, 1'b1,1'b0,16'h0012, 1'b1,16'h3333,16'h0010);
        add(16'h0012,1'b1,16'h0000,1'b0,1'b0, 1'b0,1'b0,16'h0012, 1'b1,16'hABCD,16'h0012);
        add(16'h0014,1'b1,16'h4444,1'b0,1'b0, 1'b0,1'b1,16'h0014, 1'b1,16'h4444,16'h0014);
        add(16'h0020,1'b0,16'h0000,1'b0,1'b1, 1'b0,1'b1,16'h0020, 1'b0,16'h0000,16'h0000);
        add(16'h0100,1'b0,16'h0000,1'b0,1'b0, 1'b1,1'b1,16'h0020, 1'b0,16'h0000,16'h0000);
        add(16'h0100,1'b1,16'hDEAD,1'b0,1'b0, 1'b1,1'b1,16'h0020, 1'b0,16'h0000,16'h0000);
        add(16'h0100,1'b1,16'h5555,1'b0,1'b0, 1'b0,1'b1,16'h0100, 1'b1,16'h5555,16'h0100);
        add(16'h0102,1'b1,16'h6666,1'b1,1'b1, 1'b0,1'b1,16'h0102, 1'b0,16'h0000,16'h0000);
        add(16'h0200,1'b1,16'h7777,1'b1,1'b0, 1'b0,1'b1,16'h0200, 1'b1,16'h7777,16'h0200);
        add(16'h0202,1'b1,16'h8888,1'b1,1'b0, 1'b1,1'b1,16'h0202, 1'b1,16'h7777,16'h0200);
        add(16'h0202,1'b0,16'h0000,1'b1,1'b1, 1'b0,1'b0,16'h0202, 1'b0,16'h0000,16'h0000);
        add(16'h0300,1'b1,16'h9999,1'b0,1'b0, 1'b0,1'b1,16'h0300, 1'b1,16'h9999,16'h0300);
        add(16'h0302,1'b0,16'h0000,1'b0,1'b1, 1'b0,1'b1,16'h0302, 1'b0,16'h0000,16'h0000);
        add(16'h0400,1'b0,16'h0000,1'b0,1'b1, 1'b0,1'b1,16'h0302, 1'b0,16'h0000,16'h0000);
        add(16'h0500,1'b1,16'hBEEF,1'b0,1'b0, 1'b1,1'b1,16'h0302, 1'b0,16'h0000,16'h0000);
        add(16'h0500,1'b1,16'h1234,1'b0,1'b0, 1'b0,1'b1,16'h0500, 1'b1,16'h1234,16'h0500);
        add(16'hFFFE,1'b1,16'hCAFE,1'b0,1'b0, 1'b0,1'b1,16'hFFFE, 1'b1,16'hCAFE,16'hFFFE);
        add(16'h0010,1'b1,16'hABCD,1'b1,1'b0, 1'b1,1'b1,16'h0010, 1'b1,16'hCAFE,16'hFFFE);
        foreach (vq[i]) run_vec(vq[i], i);

        // ---------------- async reset while parked in HOLD ----------------
        #1;
        chk("hold imem_req", 32'(imem_req), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        chk_reset_outputs("reset_held");
        rst_n = 1'b1;
        id_stall = 1'b0;
        #3;
        chk("post_release imem_req", 32'(imem_req), 32'd0);
        chk("post_release pc_pause", 32'(pc_pause), 32'd1);
        @(posedge clk);
        #1;
        chk("first_request imem_req", 32'(imem_req), 32'd1);

        // ---------------- randomized traffic vs reference model ----------------
        rst_n = 1'b0;
        flush = 1'b0; imem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_started = 1'b0; m_draining = 1'b0; m_drain_addr = '0;
        m_buf.delete(); m_valid = 1'b0; m_instr = '0; m_pc = '0; m_cnt = 0;
        tb_pc = 16'h0000;

        for (int n = 0; n < 3000; n++) begin
            r_rdy   = ($urandom_range(0, 3) != 0);
            r_stall = ($urandom_range(0, 3) == 0);
            r_flush = ($urandom_range(0, 7) == 0);
            r_rdata = 16'($urandom);
            pc_addr = tb_pc; imem_ready = r_rdy; imem_rdata = r_rdata;
            id_stall = r_stall; flush = r_flush;

            acc    = !m_valid || !r_stall;
            e_req  = m_started && (m_buf.size() == 0);
            e_addr = m_draining ? m_drain_addr : tb_pc;
            if (!m_started)             e_pause = 1'b1;
            else if (m_buf.size() != 0) e_pause = !(r_flush || acc);
            else if (m_draining)        e_pause = !r_flush;
            else                        e_pause = !(r_flush || (r_rdy && acc));

            #4;
            chk("rand pc_pause", 32'(pc_pause), 32'(e_pause));
            chk("rand imem_req", 32'(imem_req), 32'(e_req));
            if (e_req) chk("rand imem_addr", 32'(imem_addr), 32'(e_addr));
            @(posedge clk);
            #1;

            was_started = m_started;
            if (!m_started) begin
                m_started = 1'b1;
            end else if (m_buf.size() != 0) begin
                if (r_flush) begin
                    m_valid = 1'b0;
                    m_buf.delete();
                end else if (acc) begin
                    w = m_buf.pop_front();
                    m_valid = 1'b1; m_instr = w.instr; m_pc = w.pc;
                end
            end else if (m_draining) begin
                m_valid = 1'b0;
                if (!r_flush && r_rdy) m_draining = 1'b0;
            end else begin
                if (r_flush) begin
                    m_valid = 1'b0;
                    if (!r_rdy) begin
                        m_draining = 1'b1;
                        m_drain_addr = tb_pc;
                    end
                end else if (r_rdy) begin
                    if (acc) begin
                        m_valid = 1'b1; m_instr = r_rdata; m_pc = tb_pc;
                    end else begin
                        w.instr = r_rdata; w.pc = tb_pc;
                        m_buf.push_back(w);
                    end
                end else if (acc) begin
                    m_valid = 1'b0;
                end
            end
            if (was_started && e_pause && m_cnt < 65535) m_cnt++;

            chk("rand if_id_valid", 32'(if_id_valid), 32'(m_valid));
            if (m_valid) begin
                e_p2 = m_pc + 16'd2;
                chk("rand if_id_instr", 32'(if_id_instr), 32'(m_instr));
                chk("rand if_id_pc", 32'(if_id_pc), 32'(m_pc));
                chk("rand if_id_pc_plus2", 32'(if_id_pc_plus2), 32'(e_p2));
            end
`ifdef FETCH_STALL_CNT_EN
            chk("rand stall_count", 32'(stall_count), 32'(m_cnt));
`endif

            // Emulated PC register: loads when the stage releases it.
            if (!e_pause) begin
                if (r_flush) tb_pc = 16'($urandom) & 16'hFFFE;
                else         tb_pc = tb_pc + 16'd2;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
